// File: rtl/spi_request_arbiter.sv
// Round-robin share of one SPI_Master among NREQ requesters; SPI_STAR_O rises on the grant edge, DONE_O follows the done edge by one cycle.
// No backpressure path: requesters hold REQ_I high until DONE_O, so requests arriving while BUSY_O is high wait for IDLE.
module spi_request_arbiter #(
  parameter int NREQ      = 3,
  parameter int DATA_W    = 32,
  parameter int SEL_W     = 2,
  parameter int START_LEN = 4,
  parameter int TIMEOUT   = 4096,
  parameter int GAP_LEN   = 8
) (
  input  logic                     BOARD_CLOCK,
  input  logic                     RST,
  input  logic [NREQ-1:0]          REQ_I,
  input  logic [NREQ*DATA_W-1:0]   REQ_DATA_I,
  input  logic [NREQ*SEL_W-1:0]    REQ_SEL_I,
  output logic [NREQ-1:0]          DONE_O,
  output logic [NREQ-1:0]          ERR_O,
  output logic [DATA_W-1:0]        RDATA_O,
  output logic                     BUSY_O,
  output logic [DATA_W-1:0]        SPI_I_O,
  output logic [SEL_W-1:0]         SPI_SEL_O,
  output logic                     SPI_STAR_O,
  input  logic [DATA_W-1:0]        SPI_O_I,
  input  logic                     SPI_DONE_I
);

  localparam int PW   = $clog2(NREQ);
  localparam int CMAX = (TIMEOUT > START_LEN) ? ((TIMEOUT > GAP_LEN) ? TIMEOUT : GAP_LEN)
                                              : ((START_LEN > GAP_LEN) ? START_LEN : GAP_LEN);
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] START_LAST = CW'(START_LEN - 1);
  // Timeout is decided one edge early so DONE_O/ERR_O land exactly TIMEOUT cycles after WAIT entry.
  localparam logic [CW-1:0] WAIT_LAST  = CW'(TIMEOUT - 2);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_LEN - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]    state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] gnt;
  logic [CW-1:0] cnt;
  logic          done_prev;
  logic          err_flag;
  logic          done_edge;
  logic [PW-1:0] pick;
  logic [PW-1:0] idx;
  logic          pick_vld;

  assign done_edge = SPI_DONE_I & ~done_prev;

  // Scan from the farthest offset down so the nearest active requester at/after ptr wins.
  always_comb begin
    pick     = '0;
    idx      = '0;
    pick_vld = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = PW'((int'(ptr) + i) % NREQ);
      if (REQ_I[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge BOARD_CLOCK) begin
    if (RST) begin
      state      <= S_IDLE;
      ptr        <= '0;
      gnt        <= '0;
      cnt        <= '0;
      done_prev  <= 1'b0;
      err_flag   <= 1'b0;
      DONE_O     <= '0;
      ERR_O      <= '0;
      RDATA_O    <= '0;
      BUSY_O     <= 1'b0;
      SPI_I_O    <= '0;
      SPI_SEL_O  <= '0;
      SPI_STAR_O <= 1'b0;
    end else begin
      done_prev <= SPI_DONE_I;
      DONE_O    <= '0;
      ERR_O     <= '0;
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            gnt        <= pick;
            SPI_I_O    <= REQ_DATA_I[int'(pick)*DATA_W +: DATA_W];
            SPI_SEL_O  <= REQ_SEL_I[int'(pick)*SEL_W +: SEL_W];
            SPI_STAR_O <= 1'b1;
            BUSY_O     <= 1'b1;
            cnt        <= '0;
            state      <= S_START;
          end
        end
        S_START: begin
          if (cnt == START_LAST) begin
            SPI_STAR_O <= 1'b0;
            cnt        <= '0;
            state      <= S_WAIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (done_edge) begin
            RDATA_O  <= SPI_O_I;
            err_flag <= 1'b0;
            state    <= S_RESP;
          end else if (cnt == WAIT_LAST) begin
            RDATA_O  <= '0;
            err_flag <= 1'b1;
            state    <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: begin
          DONE_O[gnt] <= 1'b1;
          ERR_O[gnt]  <= err_flag;
          if (int'(gnt) == NREQ - 1) ptr <= '0;
          else                       ptr <= gnt + 1'b1;
          cnt   <= '0;
          state <= S_GAP;
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            BUSY_O <= 1'b0;
            state  <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
